// File: rtl/ysyx_22040125_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040125_trap_ctrl
// Purpose  : ebreak / watchdog halt sequencer with cycle and instret counters
// Revision : 1.0
// ============================================================================
module ysyx_22040125_trap_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int WDT_WIDTH    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic        retire_ebreak,
    input  logic [63:0] retire_pc,
    input  logic [63:0] retire_a0,
    input  logic        mem_busy,
    output logic        fetch_stop,
    output logic        halt,
    output logic [1:0]  halt_cause,
    output logic [63:0] halt_code,
    output logic [63:0] halt_pc,
    output logic        good_trap,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_DRAIN    = 2'd1;
    localparam logic [1:0] c_WAIT_MEM = 2'd2;
    localparam logic [1:0] c_HALTED   = 2'd3;

    localparam int              c_DW         = $clog2(DRAIN_CYCLES + 2);
    localparam logic [c_DW-1:0] c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES);
    localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);

    logic [1:0]           r_state;
    logic [c_DW-1:0]      r_drain;
    logic [WDT_WIDTH-1:0] r_wdt;
    logic [63:0]          r_last_pc;
    logic                 r_fetch_stop;
    logic                 r_halt;
    logic [1:0]           r_cause;
    logic [63:0]          r_code;
    logic [63:0]          r_pc;
    logic                 r_good_trap;
    logic [63:0]          r_cycle;
    logic [63:0]          r_instret;

    logic [1:0]           w_ebreak_next;
    logic                 w_wdt_expired;

    // With no drain stages the trap goes straight to waiting on memory.
    generate
        if (DRAIN_CYCLES == 0) begin : g_no_drain
            assign w_ebreak_next = c_WAIT_MEM;
        end else begin : g_drain
            assign w_ebreak_next = c_DRAIN;
        end
    endgenerate

    assign w_wdt_expired = &r_wdt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_RUN;
            r_drain      <= '0;
            r_wdt        <= '0;
            r_last_pc    <= '0;
            r_fetch_stop <= 1'b0;
            r_halt       <= 1'b0;
            r_cause      <= 2'd0;
            r_code       <= '0;
            r_pc         <= '0;
            r_good_trap  <= 1'b0;
            r_cycle      <= '0;
            r_instret    <= '0;
        end else begin
            if (r_state != c_HALTED) begin
                r_cycle <= r_cycle + 64'd1;
            end
            case (r_state)
                c_RUN: begin
                    // A retire always clears the watchdog, so ebreak beats expiry.
                    if (retire_valid) begin
                        r_instret <= r_instret + 64'd1;
                        r_wdt     <= '0;
                        r_last_pc <= retire_pc;
                        if (retire_ebreak) begin
                            r_pc         <= retire_pc;
                            r_code       <= retire_a0;
                            r_cause      <= 2'd1;
                            r_fetch_stop <= 1'b1;
                            r_drain      <= c_DRAIN_LOAD;
                            r_state      <= w_ebreak_next;
                        end
                    end else if (w_wdt_expired) begin
                        r_pc         <= r_last_pc;
                        r_code       <= '1;
                        r_cause      <= 2'd2;
                        r_fetch_stop <= 1'b1;
                        r_state      <= c_WAIT_MEM;
                    end else begin
                        r_wdt <= r_wdt + WDT_WIDTH'(1);
                    end
                end
                c_DRAIN: begin
                    if (r_drain == c_DRAIN_ONE) begin
                        r_state <= c_WAIT_MEM;
                    end else begin
                        r_drain <= r_drain - c_DRAIN_ONE;
                    end
                end
                c_WAIT_MEM: begin
                    if (!mem_busy) begin
                        r_state     <= c_HALTED;
                        r_halt      <= 1'b1;
                        r_good_trap <= (r_cause == 2'd1) && (r_code == 64'd0);
                    end
                end
                c_HALTED: begin
                    r_state <= c_HALTED;
                end
                default: begin
                    r_state <= c_RUN;
                end
            endcase
        end
    end

    assign fetch_stop  = r_fetch_stop;
    assign halt        = r_halt;
    assign halt_cause  = r_cause;
    assign halt_code   = r_code;
    assign halt_pc     = r_pc;
    assign good_trap   = r_good_trap;
    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;

endmodule
`default_nettype wire
